cd_sector_sink: RTL
===================

# cd_sector_sink

CDIC-side consumer of the CD sector cache stream. Issues seek/stop commands and the 75 Hz (or 150 Hz) sector tick toward the cache, receives the 16-bit word stream of each delivered sector, validates sync, extracts header/subheader and writes sector words into a double-buffered CDIC sector RAM. Sits between the CDIC command/register logic and the HPS sector cache.

## Interface
Parameters:
- CLK_HZ, 30000000, system clock frequency; sets the tick divider.
- SECTOR_WORDS, 1188, words per delivered sector: 0x930 bytes plus 12 subchannel words.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_seek  in  1  pulse: start reading at cmd_lba.
- cmd_lba  in  32  target LBA, sampled with cmd_seek.
- cmd_stop  in  1  pulse: stop reading.
- double_speed  in  1  1 = 150 Hz tick, 0 = 75 Hz.
- seek_lba  out  32  LBA toward the cache.
- seek_lba_valid  out  1  one-cycle seek pulse.
- stop_sector_delivery  out  1  one-cycle stop pulse.
- sector_tick  out  1  one-cycle tick pulse.
- cd_data  in  16  sector word.
- cd_data_valid  in  1  word strobe, at least 3 idle cycles between strobes.
- sector_delivered  in  1  end-of-sector pulse from the cache.
- buf_addr  out  12  {bank, word index[10:0]}.
- buf_wdata  out  16  word to write.
- buf_we  out  1  write strobe.
- sector_ready  out  1  pulse: good sector complete in bank ready_bank.
- ready_bank  out  1  bank holding the last good sector.
- sector_error  out  1  pulse: bad sync, short sector or overrun.
- hdr_msf  out  24  BCD minute/second/frame of the last good sector.
- hdr_mode  out  8  mode byte.
- hdr_subheader  out  32  file, channel, submode, coding.
- active  out  1  reading state.

## Operation
- States: IDLE, ACTIVE.
  - IDLE to ACTIVE on cmd_seek.
  - ACTIVE to IDLE on cmd_stop.
  - cmd_seek in ACTIVE re-seeks and stays in ACTIVE.
- On cmd_seek:
  - latch cmd_lba into seek_lba and the expected LBA.
  - pulse seek_lba_valid next cycle.
  - clear word_idx and the sync-error flag.
- On cmd_stop: pulse stop_sector_delivery next cycle. Words still arriving are written normally.
- Tick divider:
  - counter reloads at CLK_HZ/75-1, or CLK_HZ/150-1 when double_speed is set.
  - sector_tick pulses on reload.
  - runs regardless of state.
- Each cd_data_valid:
  - writes cd_data to {bank, word_idx}, then word_idx increments.
- Sync check, words 0..5:
  - word 0 must be 0xFF00, words 1-4 0xFFFF, word 5 0x00FF.
  - any mismatch sets sync_err.
- Header capture:
  - word 6 = {S,M}, word 7 = {mode,F}.
  - words 8,9 = subheader, low byte first.
  - captured into shadow registers.
- Overrun: a word with word_idx == SECTOR_WORDS is not written and sets ovr.
- On sector_delivered:
  - good when word_idx == SECTOR_WORDS, !sync_err and !ovr (and the MSF check passes, see Configuration).
  - good sector: copy shadows to hdr_* outputs, ready_bank <= bank, bank toggles, sector_ready pulses, expected LBA +1.
  - otherwise: sector_error pulses, bank unchanged, expected LBA +1.
  - either way: word_idx, sync_err and ovr are cleared.
- Words in IDLE: written and counted exactly as in ACTIVE.

## Timing
- Reset values:
  - all pulse outputs 0.
  - active 0, bank 0, ready_bank 0.
  - seek_lba 0, hdr_* 0, buf_* 0.
  - divider counter 0.
- Buffer write is registered: buf_we asserts 1 cycle after cd_data_valid, with buf_addr/buf_wdata stable that cycle.
- sector_ready/sector_error assert 2 cycles after sector_delivered, so the last word's write completes first. hdr_* and ready_bank are valid in the same cycle.
- Simultaneous cd_data_valid and sector_delivered: the word belongs to the finishing sector.
- Simultaneous cmd_seek and sector_delivered: cmd_seek wins. The sector is discarded with no ready/error pulse.
- Simultaneous cmd_seek and cmd_stop: cmd_stop wins. Only stop_sector_delivery pulses; state goes to IDLE.
- Reset mid-sector: all state cleared asynchronously and no buffer write completes.
- word_idx is 11 bits and saturates at SECTOR_WORDS.
- Expected LBA wraps modulo 2^32.

## Configuration
- CD_SECTOR_SINK_MSF_CHECK_EN defined:
  - header BCD MSF is converted to LBA = (M*60+S)*75+F-150 (32-bit, pipelined over 2 cycles inside the 2-cycle result latency).
  - a mismatch with the expected LBA makes the sector bad.
  - the expected LBA resyncs to header LBA+1.
- Not defined: MSF is captured but never compared.

## Test plan
- CLK_HZ=30000000, double_speed=0: sector_tick period 400000 cycles. double_speed=1: 200000 cycles.
- cmd_seek with cmd_lba=0x1234: seek_lba=0x1234 and one seek_lba_valid pulse. Then 1188 good words with header 00/02/00 mode 2, then sector_delivered: bank-0 writes at 0x000..0x4A3, sector_ready with ready_bank=0, hdr_msf=0x000200. The next sector lands in bank 1 (0x800..).
- Word 3 = 0xFFFE: sector_error, no sector_ready, bank stays 0.
- 1187 words, or 1189 words, before sector_delivered: sector_error. The 1189th word is not written.
- With the MSF macro defined, seek LBA 0 and header 00/02/01: sector_error. Expected LBA becomes 2, so a following 00/02/02 sector is good.
- cmd_seek in the same cycle as sector_delivered: no ready/error pulse and word_idx=0. Assert reset_n low mid-sector: outputs return to reset values immediately.

Source files
------------

// File: rtl/cd_sector_sink.sv
// CDIC-side sink for the CD sector cache stream: seek/stop/tick toward the cache,
// sector word capture into a double-buffered RAM. Optional: CD_SECTOR_SINK_MSF_CHECK_EN.
module cd_sector_sink #(
    parameter int unsigned CLK_HZ       = 30000000,
    parameter int unsigned SECTOR_WORDS = 1188
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_seek,
    input  logic [31:0] cmd_lba,
    input  logic        cmd_stop,
    input  logic        double_speed,
    output logic [31:0] seek_lba,
    output logic        seek_lba_valid,
    output logic        stop_sector_delivery,
    output logic        sector_tick,
    input  logic [15:0] cd_data,
    input  logic        cd_data_valid,
    input  logic        sector_delivered,
    output logic [11:0] buf_addr,
    output logic [15:0] buf_wdata,
    output logic        buf_we,
    output logic        sector_ready,
    output logic        ready_bank,
    output logic        sector_error,
    output logic [23:0] hdr_msf,
    output logic [7:0]  hdr_mode,
    output logic [31:0] hdr_subheader,
    output logic        active
);

    localparam int unsigned DIV_SS   = CLK_HZ / 75;
    localparam int unsigned DIV_DS   = CLK_HZ / 150;
    localparam int unsigned CW       = $clog2(DIV_SS + 1);
    localparam logic [CW-1:0] RELOAD_SS = CW'(DIV_SS - 1);
    localparam logic [CW-1:0] RELOAD_DS = CW'(DIV_DS - 1);
    localparam logic [10:0]   FULL_IDX  = 11'(SECTOR_WORDS);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   div_cnt;
    logic [10:0]     word_idx;
    logic            bank;
    logic            sync_err;
    logic            ovr;
    logic [31:0]     exp_lba;
    logic [7:0]      sh_m, sh_s, sh_f, sh_mode;
    logic [31:0]     sh_sub;
    logic            p_valid;
    logic            p_good;

    logic            seek_go;
    logic            word_fits;
    logic [10:0]     fin_idx;
    logic            fin_ovr;
    logic            sync_bad;
    logic            res_good;
    logic [31:0]     exp_nxt;

    // stop dominates a same-cycle seek entirely
    assign seek_go = cmd_seek & ~cmd_stop;
    assign active  = (state == ST_ACTIVE);

    always_comb begin
        state_nxt = state;
        if (cmd_stop)
            state_nxt = ST_IDLE;
        else if (cmd_seek)
            state_nxt = ST_ACTIVE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seek_lba             <= '0;
            seek_lba_valid       <= 1'b0;
            stop_sector_delivery <= 1'b0;
        end else begin
            seek_lba_valid       <= seek_go;
            stop_sector_delivery <= cmd_stop;
            if (seek_go)
                seek_lba <= cmd_lba;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            sector_tick <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt     <= double_speed ? RELOAD_DS : RELOAD_SS;
            sector_tick <= 1'b1;
        end else begin
            div_cnt     <= div_cnt - 1'b1;
            sector_tick <= 1'b0;
        end
    end

    // Sector totals including a word that arrives together with sector_delivered
    assign word_fits = cd_data_valid && (word_idx != FULL_IDX);
    assign fin_idx   = word_fits ? word_idx + 11'd1 : word_idx;
    assign fin_ovr   = ovr | (cd_data_valid & ~word_fits);

    always_comb begin
        sync_bad = 1'b0;
        if (cd_data_valid) begin
            case (word_idx)
                11'd0:                      sync_bad = (cd_data != 16'hFF00);
                11'd1, 11'd2, 11'd3, 11'd4: sync_bad = (cd_data != 16'hFFFF);
                11'd5:                      sync_bad = (cd_data != 16'h00FF);
                default:                    sync_bad = 1'b0;
            endcase
        end
    end

`ifdef CD_SECTOR_SINK_MSF_CHECK_EN
    logic [13:0] p_ms;
    logic [7:0]  p_f;
    logic [31:0] msf_lba;

    function automatic logic [7:0] bcd2bin(input logic [7:0] d);
        return 8'(d[7:4]) * 8'd10 + 8'(d[3:0]);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_ms <= '0;
            p_f  <= '0;
        end else begin
            p_ms <= 14'(bcd2bin(sh_m)) * 14'd60 + 14'(bcd2bin(sh_s));
            p_f  <= bcd2bin(sh_f);
        end
    end

    assign msf_lba  = 32'(p_ms) * 32'd75 + 32'(p_f) - 32'd150;
    assign res_good = p_good && (msf_lba == exp_lba);
    assign exp_nxt  = msf_lba + 32'd1;
`else
    assign res_good = p_good;
    assign exp_nxt  = exp_lba + 32'd1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_we        <= 1'b0;
            buf_addr      <= '0;
            buf_wdata     <= '0;
            word_idx      <= '0;
            sync_err      <= 1'b0;
            ovr           <= 1'b0;
            bank          <= 1'b0;
            ready_bank    <= 1'b0;
            exp_lba       <= '0;
            sh_m          <= '0;
            sh_s          <= '0;
            sh_f          <= '0;
            sh_mode       <= '0;
            sh_sub        <= '0;
            p_valid       <= 1'b0;
            p_good        <= 1'b0;
            sector_ready  <= 1'b0;
            sector_error  <= 1'b0;
            hdr_msf       <= '0;
            hdr_mode      <= '0;
            hdr_subheader <= '0;
        end else begin
            buf_we <= word_fits;
            if (word_fits) begin
                buf_addr  <= {bank, word_idx};
                buf_wdata <= cd_data;
            end

            if (cd_data_valid) begin
                case (word_idx)
                    11'd6: begin sh_s <= cd_data[15:8]; sh_m <= cd_data[7:0]; end
                    11'd7: begin sh_mode <= cd_data[15:8]; sh_f <= cd_data[7:0]; end
                    11'd8: sh_sub[31:16] <= {cd_data[7:0], cd_data[15:8]};
                    11'd9: sh_sub[15:0]  <= {cd_data[7:0], cd_data[15:8]};
                    default: ;
                endcase
            end

            if (seek_go || sector_delivered) begin
                word_idx <= '0;
                sync_err <= 1'b0;
                ovr      <= 1'b0;
            end else begin
                word_idx <= fin_idx;
                sync_err <= sync_err | sync_bad;
                ovr      <= fin_ovr;
            end

            p_valid <= sector_delivered & ~seek_go;
            p_good  <= (fin_idx == FULL_IDX) & ~(sync_err | sync_bad) & ~fin_ovr;

            // Bank flips on the result cycle; the cache stays quiet that long after a sector
            sector_ready <= 1'b0;
            sector_error <= 1'b0;
            if (p_valid && !seek_go) begin
                if (res_good) begin
                    hdr_msf       <= {sh_m, sh_s, sh_f};
                    hdr_mode      <= sh_mode;
                    hdr_subheader <= sh_sub;
                    ready_bank    <= bank;
                    bank          <= ~bank;
                    sector_ready  <= 1'b1;
                end else begin
                    sector_error  <= 1'b1;
                end
                exp_lba <= exp_nxt;
            end
            if (seek_go)
                exp_lba <= cmd_lba;
        end
    end

endmodule
